// File: rtl/args_window3x3.sv
// Streaming 3x3 window generator: buffers the two previous image lines and
// emits one packed window per accepted pixel whose window lies fully inside the frame.
module args_window3x3 #(
  parameter int DW = 10,
  parameter int IW = 640,
  parameter int IH = 480,
  parameter int XW = $clog2(IW),
  parameter int YW = $clog2(IH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  input  logic            in_sof,
  input  logic [DW-1:0]   in_data,
  output logic [DW*9-1:0] win,
  output logic            win_vld,
  output logic [XW-1:0]   win_x,
  output logic [YW-1:0]   win_y,
  output logic            win_eof,
  output logic            sof_err,
  output logic            dbg_state
);

  // Handshake: a pixel is accepted on every rising edge where in_vld is high
  // (and the frame has started or in_sof is high); there is no ready, and
  // win_vld is a one-cycle strobe the consumer must take when it appears.
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   col, ecol;
  logic [YW-1:0]   row, erow;
  logic            sof_q, acc, emit, frame_end, restart_err;
  logic [DW-1:0]   lb0 [IW];
  logic [DW-1:0]   lb1 [IW];
  logic [DW-1:0]   lb0_rd, lb1_rd;
  logic [DW*3-1:0] sh1, sh2, new_c2;

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (frame_end)  state_nxt = IDLE;
    else if (acc)   state_nxt = ACTIVE;
  end

  // Output / datapath control; an SOF pixel always lands at (0,0)
  always_comb begin
    sof_q       = in_vld && in_sof;
    acc         = in_vld && (state == ACTIVE || in_sof);
    ecol        = sof_q ? '0 : col;
    erow        = sof_q ? '0 : row;
    frame_end   = acc && (ecol == XW'(IW - 1)) && (erow == YW'(IH - 1));
    emit        = acc && (ecol >= XW'(2)) && (erow >= YW'(2));
    restart_err = sof_q && (state == ACTIVE) && (col != '0 || row != '0);
    lb0_rd      = lb0[ecol];
    lb1_rd      = lb1[ecol];
    new_c2      = {in_data, lb0_rd, lb1_rd};
  end

  // Line buffers are read-before-write at the same column; contents are not reset
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[ecol] <= lb0_rd;
      lb0[ecol] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      sh1     <= '0;
      sh2     <= '0;
      win     <= '0;
      win_vld <= 1'b0;
      win_x   <= '0;
      win_y   <= '0;
      win_eof <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      win_vld <= emit;
      win_eof <= frame_end;
      sof_err <= restart_err;
      if (acc) begin
        sh1 <= sh2;
        sh2 <= new_c2;
        if (ecol == XW'(IW - 1)) begin
          col <= '0;
          row <= (erow == YW'(IH - 1)) ? '0 : erow + YW'(1);
        end else begin
          col <= ecol + XW'(1);
          row <= erow;
        end
      end
      // Output window is only loaded on emit so it holds between strobes
      if (emit) begin
        win   <= {new_c2, sh2, sh1};
        win_x <= ecol - XW'(1);
        win_y <= erow - YW'(1);
      end
    end
  end

endmodule

// File: tb/tb_args_window3x3.sv
// Directed bench for args_window3x3 on a 5x4 frame with pixel value base+y*5+x.
module tb_args_window3x3;
  localparam int DW = 10;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int RW = DW*9 + XW + YW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_vld = 1'b0;
  logic            in_sof = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic [DW*9-1:0] win;
  logic            win_vld;
  logic [XW-1:0]   win_x;
  logic [YW-1:0]   win_y;
  logic            win_eof;
  logic            sof_err;
  logic            dbg_state;

  int checks = 0;
  int errors = 0;
  int n_win = 0;
  int n_eof = 0;
  int n_sof_err = 0;
  logic [DW*9-1:0] first_win, last_win;
  logic [XW-1:0]   last_x;
  logic [YW-1:0]   last_y;
  logic            last_eof;
  logic [RW-1:0]   exp_q[$];

  args_window3x3 #(.DW(DW), .IW(IW), .IH(IH), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_sof(in_sof), .in_data(in_data),
    .win(win), .win_vld(win_vld), .win_x(win_x), .win_y(win_y), .win_eof(win_eof),
    .sof_err(sof_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] exp_rec(input int base, input int x, input int y);
    logic [DW*9-1:0] w;
    logic            eof;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        w[(c*3+r)*DW +: DW] = DW'(base + (y-2+r)*IW + (x-2+c));
    eof = (x == IW-1) && (y == IH-1);
    return {w, XW'(x-1), YW'(y-1), eof};
  endfunction

  // Scoreboard: every strobe must match the oldest expected window
  always @(negedge clk) begin
    if (rst_n && sof_err) n_sof_err++;
    if (rst_n && win_vld) begin
      logic [RW-1:0] e;
      if (n_win == 0) first_win = win;
      last_win = win; last_x = win_x; last_y = win_y; last_eof = win_eof;
      n_win++;
      if (win_eof) n_eof++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: got x=%0d y=%0d win=%h, expected no window", win_x, win_y, win);
      end else begin
        e = exp_q.pop_front();
        if ({win, win_x, win_y, win_eof} !== e) begin
          errors++;
          $display("FAIL window: got %h, expected %h", {win, win_x, win_y, win_eof}, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    in_vld = v; in_sof = s; in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic send_px(input int base, input int first, input int count, input bit gaps, input bit framed);
    for (int idx = first; idx < first + count; idx++) begin
      int  x, y;
      bit  em;
      x = idx % IW;
      y = idx / IW;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, '0);
        if (x == 2) drive(1'b0, 1'b0, '0);
      end
      em = framed && x >= 2 && y >= 2;
      if (em) exp_q.push_back(exp_rec(base, x, y));
      drive(1'b1, framed && idx == 0, DW'(base + idx));
      checks++;
      if (win_vld !== em) begin
        errors++;
        $display("FAIL win_vld_latency px=%0d: got %b, expected %b", idx, win_vld, em);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic start_test();
    n_win = 0; n_eof = 0; n_sof_err = 0;
    exp_q.delete();
  endtask

  task automatic end_counts(input string name, input int exp_win, input int exp_eof, input int exp_err);
    checks++;
    if (n_win !== exp_win || n_eof !== exp_eof || n_sof_err !== exp_err || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_counts: got win=%0d eof=%0d sof_err=%0d pending=%0d, expected win=%0d eof=%0d sof_err=%0d pending=0",
               name, n_win, n_eof, n_sof_err, exp_q.size(), exp_win, exp_eof, exp_err);
    end
    checks++;
    if (dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL %s_state_idle: got %b, expected 0", name, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({win, win_vld, win_x, win_y, win_eof, sof_err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values: got win=%h vld=%b x=%0d y=%0d eof=%b err=%b st=%b, expected all 0",
               win, win_vld, win_x, win_y, win_eof, sof_err, dbg_state);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_frame();
    logic [DW*9-1:0] ref_first;
    ref_first = {10'd12, 10'd7, 10'd2, 10'd11, 10'd6, 10'd1, 10'd10, 10'd5, 10'd0};
    start_test();
    send_px(0, 0, IW*IH, 1'b0, 1'b1);
    idle(3);
    end_counts("full_frame", 6, 1, 0);
    checks++;
    if (first_win !== ref_first) begin
      errors++;
      $display("FAIL full_first_window: got %h, expected %h", first_win, ref_first);
    end
    checks++;
    if (last_win[4*DW +: DW] !== 10'd13 || last_x !== 3'd3 || last_y !== 2'd2 || last_eof !== 1'b1) begin
      errors++;
      $display("FAIL full_last_window: got center=%0d x=%0d y=%0d eof=%b, expected 13 3 2 1",
               last_win[4*DW +: DW], last_x, last_y, last_eof);
    end
    checks++;
    if (win_vld !== 1'b0 || win_eof !== 1'b0 || win[4*DW +: DW] !== 10'd13 || win_x !== 3'd3 || win_y !== 2'd2) begin
      errors++;
      $display("FAIL full_output_hold: got vld=%b eof=%b center=%0d x=%0d y=%0d, expected 0 0 13 3 2",
               win_vld, win_eof, win[4*DW +: DW], win_x, win_y);
    end
  endtask

  task automatic test_gaps();
    logic [DW*9-1:0] ref_first;
    ref_first = {10'd12, 10'd7, 10'd2, 10'd11, 10'd6, 10'd1, 10'd10, 10'd5, 10'd0};
    start_test();
    send_px(0, 0, IW*IH, 1'b1, 1'b1);
    idle(3);
    end_counts("gaps", 6, 1, 0);
    checks++;
    if (first_win !== ref_first) begin
      errors++;
      $display("FAIL gaps_first_window: got %h, expected %h", first_win, ref_first);
    end
  endtask

  task automatic test_mid_sof();
    start_test();
    send_px(0, 0, 8, 1'b0, 1'b1);
    checks++;
    if (dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL mid_sof_active: got %b, expected 1", dbg_state);
    end
    send_px(0, 0, IW*IH, 1'b0, 1'b1);
    idle(3);
    end_counts("mid_sof", 6, 1, 1);
  endtask

  task automatic test_back_to_back();
    start_test();
    send_px(0, 0, IW*IH, 1'b0, 1'b1);
    send_px(100, 0, IW*IH, 1'b0, 1'b1);
    idle(3);
    end_counts("back_to_back", 12, 2, 0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (last_win[i*DW +: DW] < 10'd106) begin
        errors++;
        $display("FAIL b2b_no_frame1_data slot %0d: got %0d, expected >= 106", i, last_win[i*DW +: DW]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_test();
    send_px(0, 0, 14, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({win, win_vld, win_x, win_y, win_eof, sof_err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame_clear: got win=%h vld=%b x=%0d y=%0d eof=%b st=%b, expected all 0",
               win, win_vld, win_x, win_y, win_eof, dbg_state);
    end
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_win = 0;
    exp_q.delete();
    send_px(0, 0, IW*IH, 1'b0, 1'b0);
    idle(3);
    end_counts("reset_no_sof", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_mid_sof();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/args_window3x3.md
# args_window3x3

Streaming 3×3 window generator: the producer side of the convolution datapath. It takes a raster-order pixel stream, buffers the two previous image lines, and emits one fully-populated 3×3 window per accepted pixel once the window lies inside the frame. The packed window bus and its valid strobe connect directly to the convolution engine's `in[DW*9-1:0]` and `ce` inputs. Throughput is one pixel per clock, with no backpressure.

## Interface
- `DW`, 10, pixel data width.
- `IW`, 640, image width in pixels (≥3).
- `IH`, 480, image height in lines (≥3).
- `XW`, `$clog2(IW)`, column counter / coordinate width.
- `YW`, `$clog2(IH)`, row counter / coordinate width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_vld` in 1: pixel valid; the pixel is accepted on every cycle where this is high.
- `in_sof` in 1: start of frame; qualified by `in_vld`; marks pixel (0,0).
- `in_data` in DW: pixel value.
- `win` out DW*9: packed window. Slot i = c*3+r occupies `win[i*DW+:DW]`.
  - c = column: 0 is leftmost/oldest, 2 is the current column.
  - r = row: 0 is the top row (y-2), 2 is the current line.
  - The center pixel is slot 4.
- `win_vld` out 1: one-cycle strobe per valid window; drives conv `ce`.
- `win_x` out XW: column of the window center (x-1).
- `win_y` out YW: row of the window center (y-1).
- `win_eof` out 1: high together with `win_vld` for the last window of the frame.
- `sof_err` out 1: one-cycle pulse when `in_sof` arrives while a frame is in progress.

## Operation
- **State machine:** IDLE and ACTIVE.
  - IDLE: any pixel with `in_vld`=1 and `in_sof`=0 is ignored, with no counter or buffer update.
  - `in_vld`&`in_sof` in IDLE: the pixel is accepted as (0,0) and the state moves to ACTIVE.
  - ACTIVE: each accepted pixel advances `col`. When `col`=IW-1, `col` wraps to 0 and `row` increments.
  - The accepted pixel at (IW-1, IH-1) returns the state to IDLE and clears both counters.
- **Mid-frame SOF:** `in_vld`&`in_sof` in ACTIVE when (col,row)≠(0,0) pulses `sof_err` the next cycle. The pixel is taken as (0,0) of a new frame and the state stays ACTIVE. No window is emitted for that pixel.
- **Line buffers:** two buffers, LB0 (line y-1) and LB1 (line y-2), each IW deep and DW wide, addressed by `col`. Buffer contents are not reset.
- **Per accepted pixel**, read-before-write at the same address:
  - Read `LB1[col]` and `LB0[col]`.
  - Write `LB1[col]` ← old `LB0[col]`.
  - Write `LB0[col]` ← `in_data`.
- **Window registers:** on each accepted pixel, columns shift left (c1→c0, c2→c1). The new c2 is {r0 = old `LB1[col]`, r1 = old `LB0[col]`, r2 = `in_data`}.
- **Emit condition:** an accepted pixel with col≥2 and row≥2.
  - Windows that straddle the left/right or top border are never emitted, so the per-frame count is (IW-2)*(IH-2).
  - Stale buffer data from earlier frames never reaches an emitted window.
- **Coordinates and EOF:** `win_x`=col-1 and `win_y`=row-1, evaluated at the accepted pixel. `win_eof`=1 when the accepted pixel is (IW-1, IH-1).
- **Idle gaps:** `in_vld`=0 cycles freeze all state. Gaps of any length, anywhere (including mid-line), do not change the results.

## Timing
- **Latency:** `win`, `win_vld`, `win_x`, `win_y` and `win_eof` are registered and appear exactly 1 cycle after the acceptance edge of the completing pixel.
- **Output hold:**
  - `win_vld` and `win_eof` are high for 1 cycle per event.
  - `win`, `win_x` and `win_y` hold their last values otherwise.
- **Throughput:** back-to-back windows on consecutive cycles with `in_vld` held high.
- **Reset values:** every output is 0, the state is IDLE, and col=row=0.
- **Reset mid-frame:** outputs clear immediately (asynchronous). After release, pixels are ignored until the next `in_sof`.
- **Downstream:** the conv engine latency adds on top of this block's latency. This block has no ready input.

## Test plan
All scenarios use IW=5, IH=4, DW=10, and pixel value = y*5+x.

- **Reset:** assert `rst_n`=0 mid-stream → all outputs 0 in the same cycle. Stream pixels without `in_sof` after release → no `win_vld`.
- **Full frame, continuous `in_vld`:**
  - Exactly 6 `win_vld` pulses.
  - First pulse one cycle after pixel 12: `win` slots 0..8 = 0,5,10,1,6,11,2,7,12; `win_x`=1, `win_y`=1.
  - Last pulse after pixel 19: slot 4=13, `win_x`=3, `win_y`=2, `win_eof`=1.
  - State returns to IDLE.
- **Same frame with random `in_vld` gaps (including mid-line)** → identical window contents, coordinates and count as the continuous case.
- **Mid-frame SOF:** `in_sof` at pixel 8 of frame 1, then a full clean frame → `sof_err` pulses once. The following frame yields exactly the 6 correct windows.
- **Two frames back-to-back, second frame value = 100+y*5+x:**
  - Second-frame first window = 100,105,110,101,106,111,102,107,112.
  - No window contains frame-1 data.
  - `win_eof` is seen twice.
